// File: rtl/flt_pkg.sv
// Shared definitions for the floating-point write-back scheduler:
// default sizes, requester slot assignments and a one-hot decode helper.
package flt_pkg;

    localparam int FLT_NREQ = 4;   // write-back requesters
    localparam int FLT_AW   = 5;   // FP register address width (32 regs)
    localparam int FLT_DW   = 32;  // FP data width

    // Fixed requester slots; under fixed priority, a lower index wins.
    localparam int FLT_REQ_ADD = 0;
    localparam int FLT_REQ_MUL = 1;
    localparam int FLT_REQ_DIV = 2;
    localparam int FLT_REQ_LD  = 3;

    // Index of the lowest set bit of a one-hot (or zero) vector; 0 when empty.
    function automatic int flt_oh2idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/flt_wb_arbiter.sv
// Single-grant arbiter for the FP register-file write port.
// Configuration macro FLT_WB_RR_EN: defined -> round-robin with a pointer
// register; undefined -> fixed priority, lowest index wins (no state).
module flt_wb_arbiter
    import flt_pkg::*;
#(
    parameter int NREQ = FLT_NREQ,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
`ifdef FLT_WB_RR_EN
    input  logic            clk,
    input  logic            rst,
`endif
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    int base;

`ifdef FLT_WB_RR_EN
    logic [IW-1:0] ptr;

    // Search starts at the pointer.
    always_comb base = int'(ptr);

    // Pointer moves past the winner after every transfer, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    // Fixed priority: search always starts at requester 0.
    always_comb base = 0;
`endif

    // Scan from base, wrapping, and grant the first requester found.
    always_comb begin
        int   k;
        logic found;
        grant = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = base + i;
            if (k >= NREQ) k = k - NREQ;
            if (!found && req[k[IW-1:0]]) begin
                grant[k[IW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    // Encoded winner for the data/address mux in the write stage.
    always_comb grant_idx = IW'(flt_oh2idx(32'(grant)));

endmodule

// File: rtl/flt_wb_scheduler.sv
// FP write-back scheduler and scoreboard: arbitrates the register-file write
// port, registers the winning result, and tracks one busy bit per FP register
// so decode can stall on RAW/WAW hazards. Configuration macro FLT_WB_RR_EN
// selects round-robin arbitration (default: fixed priority).
//
// Handshake: requester i transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; it must hold req_valid/req_reg/req_data stable
// until then. req_ready depends only on req_valid and the arbiter pointer.
module flt_wb_scheduler
    import flt_pkg::*;
#(
    parameter int NREQ = FLT_NREQ,
    parameter int AW   = FLT_AW,
    parameter int DW   = FLT_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_reg,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               flt_reg_wr,
    output logic [AW-1:0]      flt_wr_reg,
    output logic [DW-1:0]      wr_dt,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_reg,
    input  logic [2:0]         chk_en,
    input  logic [AW-1:0]      chk_reg1,
    input  logic [AW-1:0]      chk_reg2,
    input  logic [AW-1:0]      chk_wreg,
    output logic               stall,
    output logic [2**AW-1:0]   busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] grant_idx;
    logic          xfer;

    flt_wb_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
`ifdef FLT_WB_RR_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .req       (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    // A transfer happens whenever some granted requester is valid.
    always_comb xfer = |(req_valid & req_ready);

    // Write stage: register the winner; address and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_reg_wr <= 1'b0;
            flt_wr_reg <= '0;
            wr_dt      <= '0;
        end else begin
            flt_reg_wr <= xfer;
            if (xfer) begin
                flt_wr_reg <= req_reg[int'(grant_idx)*AW +: AW];
                wr_dt      <= req_data[int'(grant_idx)*DW +: DW];
            end
        end
    end

    // Scoreboard: clear on the register-file write edge, set on issue;
    // the set is applied last so it wins a same-index collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (flt_reg_wr) busy[flt_wr_reg] <= 1'b0;
            if (iss_valid)  busy[iss_reg]    <= 1'b1;
        end
    end

    // Hazard detect: any enabled source/dest register still in flight.
    always_comb begin
        stall = (chk_en[0] & busy[chk_reg1]) |
                (chk_en[1] & busy[chk_reg2]) |
                (chk_en[2] & busy[chk_wreg]);
    end

endmodule

// File: tb/tb_flt_wb_scheduler.sv
// Directed bench for flt_wb_scheduler; checks are immediate assertions.
// Contention expectations follow FLT_WB_RR_EN as compiled.
module tb_flt_wb_scheduler;
    import flt_pkg::*;

    localparam int NREQ = FLT_NREQ;
    localparam int AW   = FLT_AW;
    localparam int DW   = FLT_DW;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_reg;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               flt_reg_wr;
    logic [AW-1:0]      flt_wr_reg;
    logic [DW-1:0]      wr_dt;
    logic               iss_valid;
    logic [AW-1:0]      iss_reg;
    logic [2:0]         chk_en;
    logic [AW-1:0]      chk_reg1;
    logic [AW-1:0]      chk_reg2;
    logic [AW-1:0]      chk_wreg;
    logic               stall;
    logic [2**AW-1:0]   busy;

    int checks = 0;
    int errors = 0;

    flt_wb_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .flt_reg_wr (flt_reg_wr),
        .flt_wr_reg (flt_wr_reg),
        .wr_dt      (wr_dt),
        .iss_valid  (iss_valid),
        .iss_reg    (iss_reg),
        .chk_en     (chk_en),
        .chk_reg1   (chk_reg1),
        .chk_reg2   (chk_reg2),
        .chk_wreg   (chk_wreg),
        .stall      (stall),
        .busy       (busy)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
        req_reg[i*AW +: AW]  = r;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int exp_g;
        rst = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
        iss_valid = 1'b0; iss_reg = '0; chk_en = '0;
        chk_reg1 = '0; chk_reg2 = '0; chk_wreg = '0;
        #1 rst = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_wr",    64'(flt_reg_wr), 64'd0);
        chk("rst_reg",   64'(flt_wr_reg), 64'd0);
        chk("rst_dt",    64'(wr_dt),      64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_ready", 64'(req_ready),  64'd0);
        chk("rst_stall", 64'(stall),      64'd0);
        rst = 1'b0;
        tick();

        // Issue reg 7, then check RAW stall via src1
        iss_valid = 1'b1; iss_reg = 5'd7;
        chk_en = 3'b001; chk_reg1 = 5'd7;
        #1 chk("iss_stall_pre", 64'(stall), 64'd0);
        tick();
        iss_valid = 1'b0;
        chk("iss_busy7", 64'(busy), 64'h80);
        chk("iss_stall", 64'(stall), 64'd1);

        // Requester 1 writes reg 7
        set_req(1, 5'd7, 32'h40490FDB);
        req_valid = 4'b0010;
        #1 chk("w_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        chk("w_pulse", 64'(flt_reg_wr), 64'd1);
        chk("w_reg",   64'(flt_wr_reg), 64'd7);
        chk("w_dt",    64'(wr_dt),      64'h40490FDB);
        chk("w_busy_held",  64'(busy),  64'h80);
        chk("w_stall_held", 64'(stall), 64'd1);
        tick();
        chk("w_pulse_end", 64'(flt_reg_wr), 64'd0);
        chk("w_dt_hold",   64'(wr_dt),      64'h40490FDB);
        chk("w_busy_clr",  64'(busy),       64'd0);
        chk("w_stall_clr", 64'(stall),      64'd0);

        // Asynchronous reset mid-transfer
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 32'h3F800000 + DW'(i));
        req_valid = 4'b1111;
        iss_valid = 1'b1; iss_reg = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk("ar_pre_wr",   64'(flt_reg_wr), 64'd1);
        chk("ar_pre_busy", 64'(busy),       64'h200);
        #2 rst = 1'b1;
        #1;
        chk("ar_wr",   64'(flt_reg_wr), 64'd0);
        chk("ar_reg",  64'(flt_wr_reg), 64'd0);
        chk("ar_dt",   64'(wr_dt),      64'd0);
        chk("ar_busy", 64'(busy),       64'd0);
        req_valid = '0;
        #1 chk("ar_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Contention with all four requesters valid
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
`ifdef FLT_WB_RR_EN
            exp_g = i % NREQ;
`else
            exp_g = 0;
`endif
            #1 chk("ct_ready", 64'(req_ready), 64'(1 << exp_g));
            tick();
            chk("ct_pulse", 64'(flt_reg_wr), 64'd1);
            chk("ct_reg",   64'(flt_wr_reg), 64'(10 + exp_g));
            chk("ct_dt",    64'(wr_dt),      64'(32'h3F800000 + exp_g));
        end
        req_valid = '0;
        tick();
        chk("ct_idle", 64'(flt_reg_wr), 64'd0);

        // Set/clear collision on reg 3
        iss_valid = 1'b1; iss_reg = 5'd3;
        tick();
        iss_valid = 1'b0;
        chk("col_busy_set", 64'(busy), 64'h8);
        set_req(0, 5'd3, 32'hC0000000);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        iss_valid = 1'b1; iss_reg = 5'd3;
        chk("col_pulse", 64'(flt_reg_wr), 64'd1);
        chk("col_reg",   64'(flt_wr_reg), 64'd3);
        tick();
        iss_valid = 1'b0;
        chk("col_busy_wins", 64'(busy), 64'h8);
        tick();
        chk("col_busy_keep", 64'(busy), 64'h8);

        // WAW on reg 5, src2 check and register 0
        iss_valid = 1'b1; iss_reg = 5'd5;
        tick();
        iss_reg = 5'd0;
        tick();
        iss_valid = 1'b0;
        chk("waw_busy", 64'(busy), 64'h29);
        chk_wreg = 5'd5; chk_en = 3'b100;
        #1 chk("waw_stall", 64'(stall), 64'd1);
        chk_en = 3'b000;
        #1 chk("waw_off", 64'(stall), 64'd0);
        chk_en = 3'b010; chk_reg2 = 5'd4;
        #1 chk("src2_clear", 64'(stall), 64'd0);
        chk_reg2 = 5'd0;
        #1 chk("src2_reg0", 64'(stall), 64'd1);
        chk_en = 3'b101; chk_reg1 = 5'd6; chk_wreg = 5'd7;
        #1 chk("mix_clear", 64'(stall), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flt_wb_scheduler.md
# flt_wb_scheduler

Write-back scheduler and scoreboard for the floating-point register file. Up to NREQ floating-point producers (add/sub, mul, div, FP load/mtc1) compete for the register file's single write port. This block grants one producer per cycle and drives the write port from a registered stage. It also tracks a busy bit per FP register so the decode stage can stall on RAW/WAW hazards against in-flight results.

## Interface
- NREQ, default 4: number of write-back requesters.
- AW, default 5: register address width, giving 32 FP registers.
- DW, default 32: data width.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i holds a result.
- req_reg  in  NREQ*AW  destination register of requester i, in slice [i*AW +: AW].
- req_data  in  NREQ*DW  result of requester i, in slice [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- flt_reg_wr  out  1  register-file write enable.
- flt_wr_reg  out  AW  register-file write address.
- wr_dt  out  DW  register-file write data.
- iss_valid  in  1  an FP op is dispatched this cycle; only asserted when stall is low.
- iss_reg  in  AW  destination register of the dispatched op.
- chk_en  in  3  enables for the src1, src2 and dest checks.
- chk_reg1, chk_reg2, chk_wreg  in  AW each  registers checked by the decode stage.
- stall  out  1  hazard detected.
- busy  out  2**AW  scoreboard bit vector, exposed for debug and verification.

## Operation
- **Arbitration:**
  - Combinational and single-grant.
  - req_ready is all-zero when no req_valid bit is set.
  - A requester must hold req_valid, req_reg and req_data stable until it is granted.
- **Write stage:**
  - On a transfer, flt_reg_wr <= 1, flt_wr_reg <= req_reg[g] and wr_dt <= req_data[g] on the next edge.
  - With no transfer, flt_reg_wr <= 0; address and data hold their previous values.
- **Scoreboard:**
  - busy[iss_reg] is set on an edge where iss_valid is high.
  - busy[flt_wr_reg] is cleared on an edge where flt_reg_wr is high, i.e. the same edge the register file captures the data.
  - If a set and a clear hit the same index on the same edge, the set wins.
- **Stall:** combinational. stall = (chk_en[0] & busy[chk_reg1]) | (chk_en[1] & busy[chk_reg2]) | (chk_en[2] & busy[chk_wreg]).
  - The dest check blocks WAW, so at most one write per register is ever in flight and a single busy bit is sufficient.
- **No bypass:** a consumer issues at the earliest one cycle after the clearing edge.
- **Register 0:** FP register 0 is ordinary; no special-casing.
- **Reset values:**
  - flt_reg_wr = 0, flt_wr_reg = 0, wr_dt = 0.
  - busy = all zeros.
  - Round-robin pointer = 0.
  - A transfer granted in the cycle reset asserts is dropped.

## Timing
- Transfer at edge t produces the write-enable pulse during cycle t..t+1; the register file writes at edge t+1.
- busy clears at edge t+1, and stall for that register falls in the cycle after t+1.
- Issue-to-busy latency is one edge: stall reflects a new issue from the cycle after iss_valid.
- Peak throughput is one write per cycle; back-to-back grants to the same requester are allowed.
- req_ready depends only on req_valid and the pointer, never on stall.

## Configuration
- **FLT_WB_RR_EN defined:** round-robin arbitration.
  - The search starts at the pointer.
  - After a transfer by requester g, the pointer becomes (g+1) mod NREQ.
  - The pointer holds when there is no transfer.
- **Undefined:** fixed priority, lowest index wins. The pointer register is not instantiated.

## Structure
- **Package flt_pkg:**
  - NREQ, AW and DW defaults.
  - Requester index localparams: FLT_REQ_ADD=0, FLT_REQ_MUL=1, FLT_REQ_DIV=2, FLT_REQ_LD=3.
  - Helper function for one-hot-to-index conversion.
- **Sub-module flt_wb_arbiter:** request vector in, one-hot grant and grant index out, containing the pointer when FLT_WB_RR_EN is defined.
- **Top level:** scoreboard, stall logic and write stage.

## Test plan
- **Reset:** assert rst mid-transfer -> flt_reg_wr=0, busy=0 and req_ready=0 with no valids, all immediately (asynchronous).
- **Issue then write:**
  - iss_valid with iss_reg=7 -> busy[7]=1 next cycle.
  - req_valid[1], reg=7, data=0x40490FDB -> one-cycle pulse with flt_wr_reg=7, wr_dt=0x40490FDB.
  - busy[7]=0 after the write edge.
  - chk_reg1=7 with chk_en=001 -> stall=1 until that edge, then 0.
- **Contention, FLT_WB_RR_EN undefined:** req_valid=1111 held -> requester 0 granted every cycle; others starve.
- **Contention, FLT_WB_RR_EN defined:** req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and 8 consecutive write pulses.
- **Set/clear collision:** write of register 3 committing on the same edge as iss_valid with iss_reg=3 -> busy[3]=1 afterwards.
- **WAW:** busy[5]=1, chk_wreg=5 with chk_en=100 -> stall=1; with chk_en=000 -> stall=0.
